time_counter_cfg: RTL and testbench

- Parametrised successor to the team's fixed 24-hour h/m/s counter.
- Generic moduli and widths; 12/24-hour display mode; per-field set-increment pulses; input range clamping; registered hour-chime and day-wrap pulses.
- Sits between the mode/button controller and the display mux/decoder.
- Optional alarm comparator.

---
 rtl/time_pkg.sv | 30 +++
 rtl/time_counter_cfg_mod_counter.sv | 38 +++
 rtl/time_counter_cfg.sv | 154 +++++++++++++++
 tb/tb_time_counter_cfg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared constants and helpers for the parametrised h/m/s time counter.
package time_pkg;

  // Default moduli for a conventional 24-hour clock.
  localparam int SEC_MOD_DEF  = 60;
  localparam int MIN_MOD_DEF  = 60;
  localparam int HOUR_MOD_DEF = 24;

  // Default field widths matching the default moduli.
  localparam int SW_DEF = 6;
  localparam int MW_DEF = 6;
  localparam int HW_DEF = 5;

  // Width used by the 12-hour helper; wide enough for any sane hour field.
  localparam int DISP_W = 8;

  // Maps a 24-hour value (0..23) to its 12-hour display value (1..12).
  function automatic logic [DISP_W-1:0] hour_to_12h(input logic [DISP_W-1:0] h24);
    logic [DISP_W-1:0] r_h12;
    if (h24 == DISP_W'(0)) begin
      r_h12 = DISP_W'(12);
    end else if (h24 > DISP_W'(12)) begin
      r_h12 = h24 - DISP_W'(12);
    end else begin
      r_h12 = h24;
    end
    return r_h12;
  endfunction

endpackage

// File: rtl/time_counter_cfg_mod_counter.sv
// Generic modulo-MOD counter used for each time field.
// load has priority and clamps out-of-range values to zero; inc (set pulse)
// and carry_in (counting advance) both step the count by one with wrap.
// wrap_out flags that this edge advances the field from MOD-1 back to 0
// through the counting chain, and feeds the next field's carry_in.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk_1hz,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         carry_in,
  output logic [W-1:0] count,
  output logic         wrap_out
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(MOD - 1));
  assign wrap_out = carry_in & w_at_max;
  assign count    = r_count;

  // Field register: load (clamped) > step by set pulse or carry.
  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (int'(load_val) >= MOD) ? '0 : load_val;
    end else if (inc | carry_in) begin
      r_count <= w_at_max ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/time_counter_cfg.sv
// Parametrised h/m/s time counter with 12/24-hour display, set-increment
// pulses, load clamping and registered hour-chime / day-wrap pulses.
// Optional alarm comparator is built when TIME_COUNTER_ALARM_EN is defined.
module time_counter_cfg
  import time_pkg::*;
#(
  parameter int SEC_MOD  = SEC_MOD_DEF,
  parameter int MIN_MOD  = MIN_MOD_DEF,
  parameter int HOUR_MOD = HOUR_MOD_DEF,
  parameter int SW       = SW_DEF,
  parameter int MW       = MW_DEF,
  parameter int HW       = HW_DEF
) (
  input  logic          clk_1hz,
  input  logic          rst,
  input  logic          time_count_en,
  input  logic          load_en,
  input  logic [HW-1:0] hour_in,
  input  logic [MW-1:0] min_in,
  input  logic          inc_min,
  input  logic          inc_hour,
  input  logic          mode12,
  output logic [SW-1:0] sec,
  output logic [MW-1:0] min,
  output logic [HW-1:0] hour,
  output logic [HW-1:0] hour_disp,
  output logic          pm,
  output logic          chime,
  output logic          day_wrap
`ifdef TIME_COUNTER_ALARM_EN
  ,
  input  logic          alarm_set,
  input  logic [HW-1:0] alarm_hour_in,
  input  logic [MW-1:0] alarm_min_in,
  input  logic          alarm_on,
  output logic          alarm_hit
`endif
);

  logic          w_set;
  logic          w_count;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hour_wrap;
  logic [SW-1:0] w_sec;
  logic [MW-1:0] w_min;
  logic [HW-1:0] w_hour;
  logic          r_chime;
  logic          r_day_wrap;

  // Set pulses suspend counting for the cycle; load overrides everything.
  assign w_set   = inc_min | inc_hour;
  assign w_count = time_count_en & ~load_en & ~w_set;

  mod_counter #(.MOD(SEC_MOD), .W(SW)) u_sec (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .inc      (1'b0),
    .load     (load_en),
    .load_val ('0),
    .carry_in (w_count),
    .count    (w_sec),
    .wrap_out (w_sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MW)) u_min (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .inc      (inc_min & ~load_en),
    .load     (load_en),
    .load_val (min_in),
    .carry_in (w_sec_wrap),
    .count    (w_min),
    .wrap_out (w_min_wrap)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(HW)) u_hour (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .inc      (inc_hour & ~load_en),
    .load     (load_en),
    .load_val (hour_in),
    .carry_in (w_min_wrap),
    .count    (w_hour),
    .wrap_out (w_hour_wrap)
  );

  assign sec  = w_sec;
  assign min  = w_min;
  assign hour = w_hour;

  // Rollover pulses: only counting carries reach these, never loads or sets.
  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_chime    <= 1'b0;
      r_day_wrap <= 1'b0;
    end else begin
      r_chime    <= w_min_wrap;
      r_day_wrap <= w_hour_wrap;
    end
  end

  assign chime    = r_chime;
  assign day_wrap = r_day_wrap;

  // 12-hour remapping only makes sense for a 24-hour modulus.
  generate
    if (HOUR_MOD == 24) begin : g_disp24
      logic [DISP_W-1:0] w_hour12;
      assign w_hour12  = hour_to_12h(DISP_W'(w_hour));
      assign hour_disp = mode12 ? w_hour12[HW-1:0] : w_hour;
      assign pm        = (w_hour >= HW'(12));
    end else begin : g_disp_plain
      assign hour_disp = w_hour;
      assign pm        = 1'b0;
    end
  endgenerate

`ifdef TIME_COUNTER_ALARM_EN
  logic [HW-1:0] r_alarm_hour;
  logic [MW-1:0] r_alarm_min;
  logic          r_alarm_hit;
  logic [MW-1:0] w_min_next;
  logic [HW-1:0] w_hour_next;

  // Field values that a seconds wrap on this edge would produce.
  assign w_min_next  = w_min_wrap ? '0 : w_min + MW'(1);
  assign w_hour_next = w_hour_wrap ? '0 : (w_min_wrap ? w_hour + HW'(1) : w_hour);

  // Alarm time register, clamped the same way as a time load.
  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_alarm_hour <= '0;
      r_alarm_min  <= '0;
    end else if (alarm_set) begin
      r_alarm_hour <= (int'(alarm_hour_in) >= HOUR_MOD) ? '0 : alarm_hour_in;
      r_alarm_min  <= (int'(alarm_min_in) >= MIN_MOD) ? '0 : alarm_min_in;
    end
  end

  // Alarm pulse: counting lands on hh:mm:00 equal to the stored alarm.
  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= alarm_on & w_sec_wrap &
                     (w_min_next == r_alarm_min) & (w_hour_next == r_alarm_hour);
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

endmodule

// File: tb/tb_time_counter_cfg.sv
// Self-checking bench for time_counter_cfg: directed steps plus a random
// phase checked against a seconds-of-day reference model.
module tb_time_counter_cfg;

  logic       clk_1hz = 1'b0;
  logic       rst;
  logic       time_count_en, load_en, inc_min, inc_hour, mode12;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic [5:0] t_sec, t_min;
  logic [4:0] t_hour, t_disp;
  logic       t_pm, t_chime, t_day;

  logic       b_count_en, b_load_en, b_inc_min, b_inc_hour;
  logic [3:0] b_hour_in;
  logic [5:0] b_min_in;
  logic [3:0] b_sec;
  logic [5:0] b_min;
  logic [3:0] b_hour, b_disp;
  logic       b_pm, b_chime, b_day;

`ifdef TIME_COUNTER_ALARM_EN
  logic       alarm_set, alarm_on, alarm_hit;
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic       b_alarm_set, b_alarm_on, b_alarm_hit;
  logic [3:0] b_alarm_hour_in;
  logic [5:0] b_alarm_min_in;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state for the default instance.
  int ms, mm, mh, mchime, mday;

  always #5 clk_1hz = ~clk_1hz;

  time_counter_cfg dut (
    .clk_1hz(clk_1hz), .rst(rst), .time_count_en(time_count_en),
    .load_en(load_en), .hour_in(hour_in), .min_in(min_in),
    .inc_min(inc_min), .inc_hour(inc_hour), .mode12(mode12),
    .sec(t_sec), .min(t_min), .hour(t_hour), .hour_disp(t_disp),
    .pm(t_pm), .chime(t_chime), .day_wrap(t_day)
`ifdef TIME_COUNTER_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hour_in(alarm_hour_in),
    .alarm_min_in(alarm_min_in), .alarm_on(alarm_on), .alarm_hit(alarm_hit)
`endif
  );

  time_counter_cfg #(.SEC_MOD(10), .MIN_MOD(60), .HOUR_MOD(12),
                     .SW(4), .MW(6), .HW(4)) dut12 (
    .clk_1hz(clk_1hz), .rst(rst), .time_count_en(b_count_en),
    .load_en(b_load_en), .hour_in(b_hour_in), .min_in(b_min_in),
    .inc_min(b_inc_min), .inc_hour(b_inc_hour), .mode12(1'b1),
    .sec(b_sec), .min(b_min), .hour(b_hour), .hour_disp(b_disp),
    .pm(b_pm), .chime(b_chime), .day_wrap(b_day)
`ifdef TIME_COUNTER_ALARM_EN
    , .alarm_set(b_alarm_set), .alarm_hour_in(b_alarm_hour_in),
    .alarm_min_in(b_alarm_min_in), .alarm_on(b_alarm_on), .alarm_hit(b_alarm_hit)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int disp_of(input int h, input logic m12);
    if (!m12) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  // One clock of the reference model, working in seconds-of-day.
  task automatic model_step();
    int t;
    mchime = 0;
    mday   = 0;
    if (load_en) begin
      ms = 0;
      mm = (int'(min_in) < 60) ? int'(min_in) : 0;
      mh = (int'(hour_in) < 24) ? int'(hour_in) : 0;
    end else if (inc_min || inc_hour) begin
      if (inc_min)  mm = (mm + 1) % 60;
      if (inc_hour) mh = (mh + 1) % 24;
    end else if (time_count_en) begin
      t = ((mh * 60 + mm) * 60 + ms + 1) % 86400;
      ms = t % 60;
      mm = (t / 60) % 60;
      mh = t / 3600;
      mchime = (t % 3600 == 0) ? 1 : 0;
      mday   = (t == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sec"},   32'(t_sec),   ms);
    check({tag, ".min"},   32'(t_min),   mm);
    check({tag, ".hour"},  32'(t_hour),  mh);
    check({tag, ".disp"},  32'(t_disp),  disp_of(mh, mode12));
    check({tag, ".pm"},    32'(t_pm),    (mh >= 12) ? 1 : 0);
    check({tag, ".chime"}, 32'(t_chime), mchime);
    check({tag, ".day"},   32'(t_day),   mday);
`ifdef TIME_COUNTER_ALARM_EN
    check({tag, ".alarm"}, 32'(alarm_hit), 0);
`endif
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk_1hz);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    time_count_en = 1'b0; load_en = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
  endtask

  task automatic load_time(input int h, input int m);
    idle_inputs();
    load_en = 1'b1; hour_in = 5'(h); min_in = 6'(m);
    tick("load");
    load_en = 1'b0;
  endtask

  initial begin
    int hs[5];
    int ds[5];
    int ps[5];
    hs = '{0, 1, 12, 13, 23};
    ds = '{12, 1, 12, 1, 11};
    ps = '{0, 0, 1, 1, 1};

    rst = 1'b1; mode12 = 1'b1; hour_in = '0; min_in = '0;
    idle_inputs();
    b_count_en = 1'b0; b_load_en = 1'b0; b_inc_min = 1'b0; b_inc_hour = 1'b0;
    b_hour_in = '0; b_min_in = '0;
`ifdef TIME_COUNTER_ALARM_EN
    alarm_set = 1'b0; alarm_on = 1'b0; alarm_hour_in = '0; alarm_min_in = '0;
    b_alarm_set = 1'b0; b_alarm_on = 1'b0; b_alarm_hour_in = '0; b_alarm_min_in = '0;
`endif
    ms = 0; mm = 0; mh = 0; mchime = 0; mday = 0;

    // Reset state, 12-hour display of hour 0.
    #12;
    check_all("reset");
    check("reset.disp12", 32'(t_disp), 12);
    rst = 1'b0;
    mode12 = 1'b0;

    // Async reset in the middle of counting at 05:30:17.
    load_time(5, 30);
    time_count_en = 1'b1;
    for (int i = 0; i < 17; i++) tick("cnt_to_053017");
    check("pre_rst.sec", 32'(t_sec), 17);
    #2 rst = 1'b1;
    #1;
    ms = 0; mm = 0; mh = 0; mchime = 0; mday = 0;
    check_all("async_rst");
    #1 rst = 1'b0;

    // Load 23:59 then one count; out-of-range load clamps to zero.
    load_time(23, 59);
    time_count_en = 1'b1;
    tick("after_load_cnt");
    check("load_cnt.sec", 32'(t_sec), 1);
    load_time(25, 61);
    check("clamp.hour", 32'(t_hour), 0);
    check("clamp.min", 32'(t_min), 0);

    // Day rollover from 23:59:58.
    load_time(23, 59);
    time_count_en = 1'b1;
    for (int i = 0; i < 58; i++) tick("to_235958");
    tick("235959");
    tick("rollover");
    check("rollover.day", 32'(t_day), 1);
    check("rollover.chime", 32'(t_chime), 1);
    tick("after_rollover");
    check("after_rollover.day", 32'(t_day), 0);

    // Set increments at 12:59:59 while counting: no carry, sec held, no chime.
    load_time(12, 59);
    time_count_en = 1'b1;
    for (int i = 0; i < 59; i++) tick("to_125959");
    inc_min = 1'b1; inc_hour = 1'b1;
    tick("set_inc");
    inc_min = 1'b0; inc_hour = 1'b0;
    check("set_inc.hour", 32'(t_hour), 13);
    check("set_inc.min", 32'(t_min), 0);
    check("set_inc.sec", 32'(t_sec), 59);
    check("set_inc.chime", 32'(t_chime), 0);

    // 12-hour display sweep.
    mode12 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_time(hs[i], 0);
      check("sweep.disp", 32'(t_disp), ds[i]);
      check("sweep.pm", 32'(t_pm), ps[i]);
    end

    // Random phase against the reference model.
    for (int i = 0; i < 600; i++) begin
      load_en       = ($urandom_range(0, 19) == 0);
      inc_min       = ($urandom_range(0, 11) == 0);
      inc_hour      = ($urandom_range(0, 11) == 0);
      time_count_en = ($urandom_range(0, 9) != 0);
      mode12        = 1'($urandom_range(0, 1));
      hour_in       = ($urandom_range(0, 3) == 0) ? 5'd23 : 5'($urandom_range(0, 31));
      min_in        = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 63));
      tick("random");
    end
    idle_inputs();

    // 12-hour modulus, 10-second minute instance.
`ifdef TIME_COUNTER_ALARM_EN
    b_alarm_set = 1'b1; b_alarm_hour_in = 4'd13; b_alarm_min_in = 6'd62;
    b_alarm_on = 1'b1;
`endif
    b_load_en = 1'b1; b_hour_in = 4'd11; b_min_in = 6'd59;
    tick("b_load");
    b_load_en = 1'b0;
`ifdef TIME_COUNTER_ALARM_EN
    b_alarm_set = 1'b0;
`endif
    b_count_en = 1'b1;
    for (int i = 0; i < 9; i++) tick("b_cnt");
    check("b_pre.sec", 32'(b_sec), 9);
    check("b_pre.min", 32'(b_min), 59);
    check("b_pre.hour", 32'(b_hour), 11);
`ifdef TIME_COUNTER_ALARM_EN
    check("b_pre.alarm", 32'(b_alarm_hit), 0);
`endif
    tick("b_wrap");
    check("b_wrap.sec", 32'(b_sec), 0);
    check("b_wrap.min", 32'(b_min), 0);
    check("b_wrap.hour", 32'(b_hour), 0);
    check("b_wrap.disp", 32'(b_disp), 0);
    check("b_wrap.pm", 32'(b_pm), 0);
    check("b_wrap.day", 32'(b_day), 1);
    check("b_wrap.chime", 32'(b_chime), 1);
`ifdef TIME_COUNTER_ALARM_EN
    check("b_wrap.alarm", 32'(b_alarm_hit), 1);
`endif
    tick("b_after");
    check("b_after.sec", 32'(b_sec), 1);
    check("b_after.day", 32'(b_day), 0);
`ifdef TIME_COUNTER_ALARM_EN
    check("b_after.alarm", 32'(b_alarm_hit), 0);
`endif
    b_count_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
